// File: rtl/pxs_pkg.sv
// Shared stream-field layout and VGA 640x480 timing defaults for the pixel-stream source.
package pxs_pkg;
    localparam int STR_W   = 26;
    localparam int ACT_B   = 0;
    localparam int VS_B    = 1;
    localparam int HS_B    = 2;
    localparam int YC_LSB  = 3;
    localparam int XC_LSB  = 13;
    localparam int RGB_LSB = 23;
    localparam int COORD_W = 10;
    localparam int RGB_W   = 3;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic [RGB_W-1:0]   rgb;
        logic [COORD_W-1:0] xc;
        logic [COORD_W-1:0] yc;
        logic               hs;
        logic               vs;
        logic               act;
    } pxs_word_t;
endpackage

// File: rtl/pxs_wrap_counter.sv
// Modulo-MAX counter (0..MAX-1); wrap_o flags the terminal value so the next increment returns to 0.
module pxs_wrap_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         px_clk,
    input  logic         px_rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    logic [W-1:0] r_cnt;

    assign wrap_o = (r_cnt == W'(MAX - 1));
    assign cnt_o  = r_cnt;

    always_ff @(posedge px_clk or negedge px_rst_n) begin
        if (!px_rst_n)  r_cnt <= '0;
        else if (inc_i) r_cnt <= wrap_o ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/pxs_vga_timing_gen.sv
// VGA timing source: registers one 26-bit stream word per enabled px_clk from the next-coordinate counters.
// Optional colour-bar test pattern is built only when PXS_TESTPAT_EN is defined.
module pxs_vga_timing_gen
    import pxs_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL
) (
    input  logic             px_clk,
    input  logic             px_rst_n,
    input  logic             en_i,
    output logic [STR_W-1:0] RGBStr_o,
    output logic             frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] HA_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VA_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_LO = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_HI = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_LO = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_HI = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam pxs_word_t RST_WORD = '{rgb: '0, xc: '0, yc: '0,
                                       hs: ~HS_POL, vs: ~VS_POL, act: 1'b0};

    logic [COORD_W-1:0] w_hcnt, w_vcnt;
    logic               w_hwrap, w_vwrap;
    logic               w_act;
    logic [RGB_W-1:0]   w_rgb;
    pxs_word_t          w_word;
    pxs_word_t          r_word;
    logic               r_fs;

    pxs_wrap_counter #(.MAX(H_TOTAL), .W(COORD_W)) u_hcnt (
        .px_clk   (px_clk),
        .px_rst_n (px_rst_n),
        .inc_i    (en_i),
        .cnt_o    (w_hcnt),
        .wrap_o   (w_hwrap)
    );

    pxs_wrap_counter #(.MAX(V_TOTAL), .W(COORD_W)) u_vcnt (
        .px_clk   (px_clk),
        .px_rst_n (px_rst_n),
        .inc_i    (en_i & w_hwrap),
        .cnt_o    (w_vcnt),
        .wrap_o   (w_vwrap)
    );

    assign w_act = (w_hcnt < HA_C) && (w_vcnt < VA_C);

`ifdef PXS_TESTPAT_EN
    localparam int                 BAR_W    = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);

    logic [RGB_W-1:0]   r_bar;
    logic [COORD_W-1:0] r_bw;

    // Bar counters track hcnt, so r_bar is the bar of the word about to be emitted.
    always_ff @(posedge px_clk or negedge px_rst_n) begin
        if (!px_rst_n) begin
            r_bar <= '0;
            r_bw  <= '0;
        end else if (en_i) begin
            if (w_hwrap) begin
                r_bar <= '0;
                r_bw  <= '0;
            end else if (r_bw == BAR_LAST) begin
                r_bar <= r_bar + 1'b1;
                r_bw  <= '0;
            end else begin
                r_bw  <= r_bw + 1'b1;
            end
        end
    end

    assign w_rgb = w_act ? r_bar : '0;
`else
    assign w_rgb = '0;
`endif

    always_comb begin
        w_word     = RST_WORD;
        w_word.rgb = w_rgb;
        w_word.xc  = w_hcnt;
        w_word.yc  = w_vcnt;
        w_word.act = w_act;
        w_word.hs  = (w_hcnt >= HS_LO && w_hcnt < HS_HI) ? HS_POL : ~HS_POL;
        w_word.vs  = (w_vcnt >= VS_LO && w_vcnt < VS_HI) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge px_clk or negedge px_rst_n) begin
        if (!px_rst_n) begin
            r_word <= RST_WORD;
            r_fs   <= 1'b0;
        end else begin
            r_fs <= en_i && (w_hcnt == '0) && (w_vcnt == '0);
            if (en_i) r_word <= w_word;
        end
    end

    assign RGBStr_o      = r_word;
    assign frame_start_o = r_fs;
endmodule
